// File: rtl/max_pool.sv
// max_pool: 2x2 / stride-2 signed max pooling over Q16.16 feature maps held in DRAM.
// Reads each 2x2 window with one outstanding read, then writes the pooled word
// channel-major, raster order. Runs once per enable session.
// Build option: define POOL_RELU_EN to clamp negative pooled results to zero.
module max_pool #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 18,
   parameter int FMAP_WIDTH    = 28,
   parameter int FMAP_HEIGHT   = 28,
   parameter int NUM_CHNL      = 6,
   parameter int ADDR_IN_BASE  = 0,
   parameter int ADDR_OUT_BASE = 'h10000
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  enable,
   input  logic                  dram_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [ADDR_WIDTH-1:0] addr_in,
   output logic [ADDR_WIDTH-1:0] addr_out,
   output logic                  dram_en_rd,
   output logic                  dram_en_wr,
   output logic                  done
);

   // Output grid; an odd trailing column/row of the input is simply never visited.
   localparam int OW = FMAP_WIDTH / 2;
   localparam int OH = FMAP_HEIGHT / 2;

   localparam int C_W = (NUM_CHNL > 1) ? $clog2(NUM_CHNL) : 1;
   localparam int R_W = (OH > 1) ? $clog2(OH) : 1;
   localparam int X_W = (OW > 1) ? $clog2(OW) : 1;

   localparam logic [C_W-1:0] C_LAST = C_W'(NUM_CHNL - 1);
   localparam logic [R_W-1:0] R_LAST = R_W'(OH - 1);
   localparam logic [X_W-1:0] X_LAST = X_W'(OW - 1);

   localparam int IN_CHNL_SIZE  = FMAP_HEIGHT * FMAP_WIDTH;
   localparam int OUT_CHNL_SIZE = OH * OW;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]            state_reg, state_next;
   logic [C_W-1:0]        c_reg, c_next;
   logic [R_W-1:0]        r_reg, r_next;
   logic [X_W-1:0]        x_reg, x_next;
   logic [1:0]            k_reg, k_next;
   logic [DATA_WIDTH-1:0] max_reg, max_next;
   logic [DATA_WIDTH-1:0] pooled_next;
   logic [ADDR_WIDTH-1:0] rd_addr_next;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [R_W:0]          row_sel;
   logic [X_W:0]          col_sel;

   // Per-channel base addresses are constants, so the channel term needs no
   // multiplier. Tables are padded to a power of two so any counter value indexes
   // a defined entry.
   logic [ADDR_WIDTH-1:0] in_base_tbl  [2**C_W];
   logic [ADDR_WIDTH-1:0] out_base_tbl [2**C_W];

   generate
      for (genvar gi = 0; gi < 2**C_W; gi++) begin : g_chnl_base
         assign in_base_tbl[gi]  = ADDR_WIDTH'(ADDR_IN_BASE  + gi * IN_CHNL_SIZE);
         assign out_base_tbl[gi] = ADDR_WIDTH'(ADDR_OUT_BASE + gi * OUT_CHNL_SIZE);
      end
   endgenerate

   // Read address of the window element the FSM will request next cycle:
   // row 2r+k[1], column 2x+k[0]; everything wraps in ADDR_WIDTH bits.
   assign row_sel      = {r_next, k_next[1]};
   assign col_sel      = {x_next, k_next[0]};
   assign rd_addr_next = in_base_tbl[c_next]
                       + ADDR_WIDTH'(row_sel) * ADDR_WIDTH'(FMAP_WIDTH)
                       + ADDR_WIDTH'(col_sel);

   // Write address of the window currently being finished.
   assign wr_addr = out_base_tbl[c_reg]
                  + ADDR_WIDTH'(r_reg) * ADDR_WIDTH'(OW)
                  + ADDR_WIDTH'(x_reg);

`ifdef POOL_RELU_EN
   // ReLU after pooling gives the same result as ReLU before pooling.
   assign pooled_next = max_next[DATA_WIDTH-1] ? '0 : max_next;
`else
   assign pooled_next = max_next;
`endif

   // Next-state, window counters and running maximum.
   always_comb begin
      state_next = state_reg;
      c_next     = c_reg;
      r_next     = r_reg;
      x_next     = x_reg;
      k_next     = k_reg;
      max_next   = max_reg;
      case (state_reg)
         ST_IDLE: begin
            if (enable) begin
               state_next = ST_RD;
               c_next     = '0;
               r_next     = '0;
               x_next     = '0;
               k_next     = '0;
            end
         end
         ST_RD: begin
            if (!enable) begin
               // Abort: drop the window, no write is issued.
               state_next = ST_IDLE;
            end else if (dram_valid) begin
               // Strict greater-than keeps the earlier value on ties.
               if (k_reg == 2'd0 || $signed(data_in) > $signed(max_reg)) begin
                  max_next = data_in;
               end
               if (k_reg == 2'd3) begin
                  state_next = ST_WR;
               end else begin
                  k_next = k_reg + 2'd1;
               end
            end
         end
         ST_WR: begin
            if (!enable) begin
               state_next = ST_IDLE;
            end else begin
               k_next     = '0;
               state_next = ST_RD;
               if (x_reg == X_LAST) begin
                  x_next = '0;
                  if (r_reg == R_LAST) begin
                     r_next = '0;
                     if (c_reg == C_LAST) begin
                        c_next     = '0;
                        state_next = ST_DONE;
                     end else begin
                        c_next = c_reg + C_W'(1);
                     end
                  end else begin
                     r_next = r_reg + R_W'(1);
                  end
               end else begin
                  x_next = x_reg + X_W'(1);
               end
            end
         end
         ST_DONE: begin
            if (!enable) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State, counters and all outputs are registered; outputs are derived from
   // the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (srst) begin
         state_reg  <= ST_IDLE;
         c_reg      <= '0;
         r_reg      <= '0;
         x_reg      <= '0;
         k_reg      <= '0;
         max_reg    <= '0;
         data_out   <= '0;
         addr_in    <= '0;
         addr_out   <= '0;
         dram_en_rd <= 1'b0;
         dram_en_wr <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_reg  <= state_next;
         c_reg      <= c_next;
         r_reg      <= r_next;
         x_reg      <= x_next;
         k_reg      <= k_next;
         max_reg    <= max_next;
         dram_en_rd <= (state_next == ST_RD);
         dram_en_wr <= (state_next == ST_WR);
         done       <= (state_next == ST_DONE);
         if (state_next == ST_RD) begin
            addr_in <= rd_addr_next;
         end
         // Only the RD->WR transition loads the write port; otherwise it holds.
         if (state_next == ST_WR) begin
            data_out <= pooled_next;
            addr_out <= wr_addr;
         end
      end
   end

endmodule

// File: tb/tb_max_pool.sv
// tb_max_pool: directed bench for max_pool. Instance u_a is a 4x4x1 map,
// instance u_b a 5x5x2 map; each has a small DRAM responder/monitor.
module tb_max_pool;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic srst = 1'b1;

   logic        en_a = 1'b0, valid_a = 1'b0;
   logic [31:0] din_a = '0, dout_a;
   logic [17:0] ain_a, aout_a;
   logic        rd_a, wr_a, done_a;

   logic        en_b = 1'b0, valid_b = 1'b0;
   logic [31:0] din_b = '0, dout_b;
   logic [17:0] ain_b, aout_b;
   logic        rd_b, wr_b, done_b;

   max_pool #(.DATA_WIDTH(32), .ADDR_WIDTH(18), .FMAP_WIDTH(4), .FMAP_HEIGHT(4),
              .NUM_CHNL(1), .ADDR_IN_BASE(0), .ADDR_OUT_BASE('h10000)) u_a (
      .clk(clk), .srst(srst), .enable(en_a), .dram_valid(valid_a), .data_in(din_a),
      .data_out(dout_a), .addr_in(ain_a), .addr_out(aout_a),
      .dram_en_rd(rd_a), .dram_en_wr(wr_a), .done(done_a));

   max_pool #(.DATA_WIDTH(32), .ADDR_WIDTH(18), .FMAP_WIDTH(5), .FMAP_HEIGHT(5),
              .NUM_CHNL(2), .ADDR_IN_BASE(0), .ADDR_OUT_BASE('h10000)) u_b (
      .clk(clk), .srst(srst), .enable(en_b), .dram_valid(valid_b), .data_in(din_b),
      .data_out(dout_b), .addr_in(ain_b), .addr_out(aout_b),
      .dram_en_rd(rd_b), .dram_en_wr(wr_b), .done(done_b));

   typedef struct {
      logic [17:0] addr;
      logic [31:0] data;
   } wr_vec_t;

   wr_vec_t exp_ramp [4];
   wr_vec_t exp_neg  [4];
   wr_vec_t exp_b    [8];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // DRAM contents: A is a ramp (addr<<16) or all -1.0; B ch0 is addr<<16,
   // B ch1 (addr>=25) is -(addr<<16).
   int mode_a = 0;
   function automatic logic [31:0] mem_a(input logic [17:0] a, input int mode);
      if (mode == 1) return 32'hFFFF0000;
      return {a[15:0], 16'h0000};
   endfunction

   function automatic logic [31:0] mem_b(input logic [17:0] a);
      logic [31:0] v;
      v = {a[15:0], 16'h0000};
      if (a < 18'd25) return v;
      return -v;
   endfunction

   // Instance A responder/monitor state
   bit          stall_en_a = 1'b0;
   int          stall_a = 0;
   logic        prev_rd_a = 1'b0;
   logic [17:0] prev_ain_a = '0;
   int          reads_a = 0, rd_since_wr_a = 0;
   logic [17:0] wq_addr_a [$];
   logic [31:0] wq_data_a [$];

   always @(negedge clk) begin : mon_a
      if (prev_rd_a && valid_a) begin
         reads_a++;
         rd_since_wr_a++;
      end
      if (prev_rd_a && !valid_a) begin
         check("stall_addr_hold", {rd_a, ain_a}, {1'b1, prev_ain_a});
      end
      if (rd_a || wr_a) begin
         check("rd_wr_exclusive", rd_a & wr_a, 0);
      end
      if (wr_a) begin
         wq_addr_a.push_back(aout_a);
         wq_data_a.push_back(dout_a);
         check("reads_per_write", rd_since_wr_a, 4);
         rd_since_wr_a = 0;
      end
      if (!rd_a) begin
         valid_a = stall_en_a;          // stray valid outside RD must be ignored
         din_a   = 32'h7FFF0000;
      end else if (stall_a > 0) begin
         valid_a = 1'b0;
         din_a   = 32'h7FFE0000;
         stall_a--;
      end else begin
         valid_a = 1'b1;
         din_a   = mem_a(ain_a, mode_a);
         stall_a = stall_en_a ? int'($urandom_range(0, 3)) : 0;
      end
      prev_rd_a  = rd_a;
      prev_ain_a = ain_a;
   end

   // Instance B responder/monitor state
   logic        prev_rd_b = 1'b0;
   logic [17:0] prev_ain_b = '0;
   int          reads_b = 0, bad_b = 0;
   logic [17:0] wq_addr_b [$];
   logic [31:0] wq_data_b [$];

   always @(negedge clk) begin : mon_b
      int loc;
      if (prev_rd_b && valid_b) begin
         reads_b++;
         loc = int'(prev_ain_b) % 25;
         if (prev_ain_b >= 18'd50 || loc / 5 == 4 || loc % 5 == 4) bad_b++;
      end
      if (wr_b) begin
         wq_addr_b.push_back(aout_b);
         wq_data_b.push_back(dout_b);
      end
      valid_b = rd_b;
      din_b   = rd_b ? mem_b(ain_b) : 32'h0;
      prev_rd_b  = rd_b;
      prev_ain_b = ain_b;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_a();
      wq_addr_a.delete();
      wq_data_a.delete();
      reads_a = 0;
      rd_since_wr_a = 0;
      stall_a = 0;
   endtask

   task automatic run_a(output int n);
      n = 0;
      en_a = 1'b1;
      while (!done_a && n < 400) begin
         tick();
         n++;
      end
      check("run_a_done", done_a, 1);
   endtask

   task automatic cmp_a(input string tag, input int sel);
      wr_vec_t e;
      check({tag, "_wcount"}, wq_addr_a.size(), 4);
      for (int i = 0; i < 4 && i < wq_addr_a.size(); i++) begin
         e = (sel == 0) ? exp_ramp[i] : exp_neg[i];
         check($sformatf("%s_addr%0d", tag, i), wq_addr_a[i], e.addr);
         check($sformatf("%s_data%0d", tag, i), wq_data_a[i], e.data);
      end
   endtask

   task automatic check_reset_a(input string tag);
      check({tag, "_rd"}, rd_a, 0);
      check({tag, "_wr"}, wr_a, 0);
      check({tag, "_done"}, done_a, 0);
      check({tag, "_data_out"}, dout_a, 0);
      check({tag, "_addr_in"}, ain_a, 0);
      check({tag, "_addr_out"}, aout_a, 0);
   endtask

   initial begin : main
      int n;
      int act;
      logic [31:0] neg_out;
`ifdef POOL_RELU_EN
      neg_out = 32'h0;
`else
      neg_out = 32'hFFFF0000;
`endif
      exp_ramp[0] = '{addr: 18'h10000, data: 32'h00050000};
      exp_ramp[1] = '{addr: 18'h10001, data: 32'h00070000};
      exp_ramp[2] = '{addr: 18'h10002, data: 32'h000D0000};
      exp_ramp[3] = '{addr: 18'h10003, data: 32'h000F0000};
      for (int i = 0; i < 4; i++) exp_neg[i] = '{addr: 18'h10000 + 18'(i), data: neg_out};
      exp_b[0] = '{addr: 18'h10000, data: 32'h00060000};
      exp_b[1] = '{addr: 18'h10001, data: 32'h00080000};
      exp_b[2] = '{addr: 18'h10002, data: 32'h00100000};
      exp_b[3] = '{addr: 18'h10003, data: 32'h00120000};
`ifdef POOL_RELU_EN
      exp_b[4] = '{addr: 18'h10004, data: 32'h0};
      exp_b[5] = '{addr: 18'h10005, data: 32'h0};
      exp_b[6] = '{addr: 18'h10006, data: 32'h0};
      exp_b[7] = '{addr: 18'h10007, data: 32'h0};
`else
      exp_b[4] = '{addr: 18'h10004, data: 32'hFFE70000};
      exp_b[5] = '{addr: 18'h10005, data: 32'hFFE50000};
      exp_b[6] = '{addr: 18'h10006, data: 32'hFFDD0000};
      exp_b[7] = '{addr: 18'h10007, data: 32'hFFDB0000};
`endif

      // Reset state
      srst = 1'b1;
      repeat (3) tick();
      check_reset_a("reset");
      check("reset_b_done", done_b, 0);
      srst = 1'b0;
      tick();

      // Test 1: ramp, no stalls, done timing
      clear_a();
      mode_a = 0;
      run_a(n);
      checks++;
      if (n < 19 || n > 21) begin
         errors++;
         $display("FAIL t1_done_cycle actual=%0d required=19..21", n);
      end
      cmp_a("t1", 0);
      check("t1_reads", reads_a, 16);
      tick();
      check("t1_done_held", done_a, 1);
      en_a = 1'b0;
      tick();
      check("t1_done_clear", done_a, 0);
      $display("t1 ramp: %0d writes, done after %0d cycles", wq_addr_a.size(), n);

      // Test 2: all -1.0
      clear_a();
      mode_a = 1;
      run_a(n);
      cmp_a("t2", 1);
      en_a = 1'b0;
      tick();
      $display("t2 negative: %0d writes", wq_addr_a.size());

      // Test 3: random stalls plus stray valid outside RD
      clear_a();
      mode_a = 0;
      stall_en_a = 1'b1;
      run_a(n);
      cmp_a("t3", 0);
      check("t3_reads", reads_a, 16);
      stall_en_a = 1'b0;
      en_a = 1'b0;
      tick();
      tick();
      $display("t3 stalls: %0d writes in %0d cycles", wq_addr_a.size(), n);

      // Test 4: odd 5x5 map, two channels
      en_b = 1'b1;
      n = 0;
      while (!done_b && n < 600) begin
         tick();
         n++;
      end
      check("t4_done", done_b, 1);
      check("t4_wcount", wq_addr_b.size(), 8);
      for (int i = 0; i < 8 && i < wq_addr_b.size(); i++) begin
         check($sformatf("t4_addr%0d", i), wq_addr_b[i], exp_b[i].addr);
         check($sformatf("t4_data%0d", i), wq_data_b[i], exp_b[i].data);
      end
      check("t4_bad_reads", bad_b, 0);
      check("t4_reads", reads_b, 32);
      en_b = 1'b0;
      tick();
      $display("t4 5x5x2: %0d writes, %0d reads", wq_addr_b.size(), reads_b);

      // Test 5: abort during the third window's reads, then restart
      clear_a();
      mode_a = 0;
      en_a = 1'b1;
      n = 0;
      while (!(wq_addr_a.size() == 2 && rd_a) && n < 200) begin
         tick();
         n++;
      end
      check("t5_reach_win3", (wq_addr_a.size() == 2) && rd_a, 1);
      en_a = 1'b0;
      tick();
      check("t5_abort_rd", rd_a, 0);
      check("t5_abort_wr", wr_a, 0);
      check("t5_abort_done", done_a, 0);
      act = 0;
      repeat (10) begin
         tick();
         if (rd_a || wr_a || done_a) act++;
      end
      check("t5_quiet", act, 0);
      check("t5_no_write", wq_addr_a.size(), 2);
      clear_a();
      en_a = 1'b1;
      tick();
      check("t5_restart_rd", rd_a, 1);
      check("t5_restart_addr", ain_a, 0);
      run_a(n);
      cmp_a("t5", 0);
      en_a = 1'b0;
      tick();
      $display("t5 abort/restart: %0d writes after restart", wq_addr_a.size());

      // Test 6: synchronous reset during a WR cycle
      clear_a();
      en_a = 1'b1;
      n = 0;
      while (!wr_a && n < 50) begin
         tick();
         n++;
      end
      check("t6_reach_wr", wr_a, 1);
      srst = 1'b1;
      tick();
      check_reset_a("t6");
      srst = 1'b0;
      en_a = 1'b0;
      tick();
      $display("t6 reset in WR: outputs cleared");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
